cvxif_offload_initiator: RTL and testbench
==========================================

# cvxif_offload_initiator

Core-side initiator of the CoreV-X-Interface: accepts one decoded offload candidate at a time from the issue stage and drives it to a coprocessor over the issue interface. It then issues the matching commit (or commit-kill) and collects results back into a register-file write port. It sits between the CVA6 issue stage and any CV-X-IF responder, and tracks outstanding transactions with a credit counter.

## Interface
- MaxOutstanding, default 4: maximum issued-and-accepted instructions without result (1..15).
- TimeoutCycles, default 255: result-wait limit, used only with the timeout feature.
- clk_i  in  1  clock
- rst_ni  in  1  reset rst_ni, asynchronous, active-low
- instr_valid_i  in  1  offload candidate valid
- instr_ready_o  out  1  candidate consumed (decision taken)
- instr_i  in  32  instruction word
- rs1_i, rs2_i  in  32 each  operand values
- id_i  in  cvxif_pkg::X_ID_WIDTH  instruction id
- flush_i  in  1  pipeline flush; kills any candidate not yet committed
- cvxif_req_o  out  cvxif_req_t  issue/commit/result-ready toward coprocessor
- cvxif_resp_i  in  cvxif_resp_t  ready/accept/result from coprocessor
- wb_valid_o  out  1  register write strobe
- wb_rd_o  out  5  destination register
- wb_data_o  out  32  write data
- wb_id_o  out  X_ID_WIDTH  id of written result
- illegal_o  out  1  one-cycle pulse: candidate rejected (raise illegal-instruction)
- busy_o  out  1  outstanding count non-zero or FSM not IDLE
- timeout_o  out  1  sticky result-timeout flag

## Operation
- FSM states: IDLE, ISSUE, COMMIT, STALL.
- IDLE: when instr_valid_i is high and outstanding < MaxOutstanding, latch instr/rs1/rs2/id, go to ISSUE. At MaxOutstanding, go to STALL.
- STALL: wait for a result to free a credit, then behave as IDLE.
- ISSUE: x_issue_valid=1 with latched fields and rs_valid=2'b11, held stable until x_issue_ready=1. On that handshake cycle, sample resp.accept and resp.writeback, record flush_i, go to COMMIT.
- COMMIT: single cycle. x_commit_valid=1, x_commit.id=latched id, x_commit_kill = (~accept) | flush seen during ISSUE/COMMIT. instr_ready_o=1 this cycle. illegal_o=1 if ~accept and no flush. Return to IDLE.
- flush_i in IDLE/STALL: no effect (nothing latched). flush_i during ISSUE: valid is not retracted; the handshake completes and is then committed with kill.
- Outstanding counter: +1 in COMMIT when accept & ~kill. −1 on result handshake. Simultaneous +1/−1 leaves it unchanged. Underflow (a result with counter 0) is ignored and does not wrap.
- Result path: x_result_ready is held 1. On x_result_valid, wb_valid_o = result.we, wb_rd_o = result.rd, wb_data_o = result.data, wb_id_o = result.id, all registered.
- x_compressed_valid, x_mem_ready, and x_mem_result_valid are tied 0.

## Timing
- Reset: FSM IDLE, counter 0, all cvxif_req_o fields 0. instr_ready_o, wb_valid_o, illegal_o, busy_o, timeout_o are 0. wb_rd_o, wb_data_o, wb_id_o are 0.
- Issue valid rises the cycle after instr_valid_i is sampled in IDLE. Minimum candidate-to-commit latency is 2 cycles (ISSUE with ready=1, then COMMIT).
- Commit is always exactly one cycle after the issue handshake.
- Result to wb_valid_o latency: 1 cycle.
- Throughput: one offload per 3 cycles maximum.
- Reset asserted mid-transaction clears all state immediately. No commit is emitted for the interrupted instruction.

## Configuration
- CVXIF_INITIATOR_TIMEOUT_EN defined:
  - An 8-bit-or-wider wait counter increments each cycle while outstanding>0 and no result arrives.
  - It resets on every result handshake.
  - Reaching TimeoutCycles sets timeout_o; it clears only on reset.
- Undefined: no counter is built and timeout_o is tied 0.

## Test plan
- Accept: instr 0x0000002B, rs1 0x01020304, rs2 0x01010101, id 3. Responder accepts with writeback=1 and returns data 0x0000000A, rd 5. Expect commit kill=0 one cycle after handshake, then wb_valid_o=1, wb_rd_o=5, wb_data_o=0x0000000A, wb_id_o=3.
- Reject: responder accept=0. Expect commit kill=1, illegal_o pulse of 1 cycle, counter stays 0, busy_o returns to 0.
- Flush: issue_ready held low 3 cycles with flush_i pulsed in cycle 2, responder accepts. Expect commit kill=1, no illegal_o, counter 0.
- Credits: MaxOutstanding=4, 5 back-to-back accepted instructions, results withheld. Expect FSM in STALL after the 4th. The 5th issues one cycle after the first result handshake.
- Simultaneous: COMMIT of an accepted instruction coincides with a result handshake. Expect the counter unchanged.
- Timeout (macro on, TimeoutCycles=16): one accepted instruction, no result. Expect timeout_o=1 at cycle 16 after commit, staying high until reset.

Source files
------------

// File: rtl/cvxif_offload_initiator.sv
// rtl/cvxif_offload_initiator.sv - CV-X-IF core-side offload initiator (issue, commit, result writeback)
//
// Purpose:
//   Takes one decoded offload candidate at a time from the issue stage and
//   offers it to a coprocessor on the CV-X-IF issue interface. The next cycle
//   it commits the instruction, or kills it if the coprocessor rejected it or a
//   flush arrived. Results are forwarded to a register-file write port. A
//   credit counter bounds the number of accepted instructions that are still
//   waiting for a result.
//
// Optional feature macro: CVXIF_INITIATOR_TIMEOUT_EN
//   When defined, a wait counter runs while results are outstanding.
//   timeout_o becomes a sticky flag that sets after TimeoutCycles cycles with
//   no result. When undefined, the counter is not built and timeout_o is 0.
//
// Parameters:
//   MaxOutstanding  accepted instructions allowed without a result (1..15)
//   TimeoutCycles   result-wait limit (used only with the timeout macro)
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   instr_valid_i/ready_o     candidate handshake (ready = decision taken)
//   instr_i, rs1_i, rs2_i     instruction word and operand values
//   id_i                      instruction id
//   flush_i                   kills any candidate not yet committed
//   cvxif_req_o/cvxif_resp_i  CV-X-IF request/response bundles
//   wb_valid_o/rd_o/data_o/id_o  registered result writeback
//   illegal_o                 one-cycle pulse when a candidate is rejected
//   busy_o                    results outstanding or transaction in flight
//   timeout_o                 sticky result-timeout flag

package cvxif_pkg;
    localparam int X_ID_WIDTH = 4;

    typedef struct packed {
        logic [31:0]           instr;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
        logic [1:0]            rs_valid;
        logic [X_ID_WIDTH-1:0] id;
    } x_issue_req_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
    } x_result_t;

    typedef struct packed {
        logic         x_compressed_valid;
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_commit_valid;
        x_commit_t    x_commit;
        logic         x_mem_ready;
        logic         x_mem_result_valid;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic          x_issue_ready;
        x_issue_resp_t x_issue_resp;
        logic          x_result_valid;
        x_result_t     x_result;
    } cvxif_resp_t;
endpackage

module cvxif_offload_initiator
    import cvxif_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [31:0]           rs1_i,
    input  logic [31:0]           rs2_i,
    input  logic [X_ID_WIDTH-1:0] id_i,
    input  logic                  flush_i,
    output cvxif_req_t            cvxif_req_o,
    input  cvxif_resp_t           cvxif_resp_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic [31:0]           wb_data_o,
    output logic [X_ID_WIDTH-1:0] wb_id_o,
    output logic                  illegal_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2,
        S_STALL  = 2'd3
    } state_e;

    localparam logic [3:0] MAX_CNT = 4'(MaxOutstanding);

    state_e                r_state;
    state_e                w_state_next;
    logic [3:0]            r_outstanding;
    logic [3:0]            w_outstanding_next;
    logic [31:0]           r_instr;
    logic [31:0]           r_rs1;
    logic [31:0]           r_rs2;
    logic [X_ID_WIDTH-1:0] r_id;
    logic                  r_accept;
    logic                  r_writeback;
    logic                  r_flush_seen;
    logic                  r_result_ready;

    logic w_result_hs;
    logic w_issue_hs;
    logic w_credit_free;
    logic w_latch;
    logic w_commit;
    logic w_kill;
    logic w_inc;
    logic w_dec;

    // Result-ready is a constant 1 in operation but must read 0 while in reset.
    assign w_result_hs = cvxif_resp_i.x_result_valid & r_result_ready;
    assign w_issue_hs  = (r_state == S_ISSUE) & cvxif_resp_i.x_issue_ready;
    assign w_commit    = (r_state == S_COMMIT);

    // A result arriving this cycle frees its credit immediately, so a stalled
    // candidate can move to ISSUE on the same edge as the result handshake.
    assign w_credit_free = (r_outstanding < MAX_CNT) |
                           (w_result_hs & (r_outstanding != 4'd0));

    // A flush arriving in the commit cycle itself still kills the instruction.
    assign w_kill = ~r_accept | r_flush_seen | flush_i;
    assign w_inc  = w_commit & ~w_kill;
    assign w_dec  = w_result_hs & (r_outstanding != 4'd0);

    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_inc, w_dec})
            2'b10:   w_outstanding_next = r_outstanding + 4'd1;
            2'b01:   w_outstanding_next = r_outstanding - 4'd1;
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE, S_STALL: begin
                if (instr_valid_i && w_credit_free) begin
                    w_latch      = 1'b1;
                    w_state_next = S_ISSUE;
                end else if (instr_valid_i) begin
                    w_state_next = S_STALL;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_issue_hs) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_outstanding  <= 4'd0;
            r_instr        <= 32'd0;
            r_rs1          <= 32'd0;
            r_rs2          <= 32'd0;
            r_id           <= '0;
            r_accept       <= 1'b0;
            r_writeback    <= 1'b0;
            r_flush_seen   <= 1'b0;
            r_result_ready <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_outstanding  <= w_outstanding_next;
            r_result_ready <= 1'b1;
            if (w_latch) begin
                r_instr      <= instr_i;
                r_rs1        <= rs1_i;
                r_rs2        <= rs2_i;
                r_id         <= id_i;
                r_flush_seen <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                if (flush_i) begin
                    r_flush_seen <= 1'b1;
                end
                if (w_issue_hs) begin
                    r_accept    <= cvxif_resp_i.x_issue_resp.accept;
                    r_writeback <= cvxif_resp_i.x_issue_resp.writeback;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= 5'd0;
            wb_data_o  <= 32'd0;
            wb_id_o    <= '0;
        end else if (w_result_hs) begin
            wb_valid_o <= cvxif_resp_i.x_result.we;
            wb_rd_o    <= cvxif_resp_i.x_result.rd;
            wb_data_o  <= cvxif_resp_i.x_result.data;
            wb_id_o    <= cvxif_resp_i.x_result.id;
        end else begin
            wb_valid_o <= 1'b0;
        end
    end

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = (r_state == S_ISSUE);
        cvxif_req_o.x_issue_req.instr    = r_instr;
        cvxif_req_o.x_issue_req.rs1      = r_rs1;
        cvxif_req_o.x_issue_req.rs2      = r_rs2;
        cvxif_req_o.x_issue_req.rs_valid = {2{r_state == S_ISSUE}};
        cvxif_req_o.x_issue_req.id       = r_id;
        cvxif_req_o.x_commit_valid       = w_commit;
        cvxif_req_o.x_commit.id          = r_id;
        cvxif_req_o.x_commit.commit_kill = w_commit & w_kill;
        cvxif_req_o.x_result_ready       = r_result_ready;
    end

    assign instr_ready_o = w_commit;
    assign illegal_o     = w_commit & ~r_accept & ~r_flush_seen & ~flush_i;
    assign busy_o        = (r_outstanding != 4'd0) | (r_state != S_IDLE);

    // The writeback request bit is captured for the commit record; nothing
    // downstream consumes it yet.
    logic w_unused_writeback;
    assign w_unused_writeback = r_writeback;

`ifdef CVXIF_INITIATOR_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TimeoutCycles + 1) > 8) ?
                                   $clog2(TimeoutCycles + 1) : 8;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TimeoutCycles);

    logic [TO_W-1:0] r_wait;
    logic [TO_W-1:0] w_wait_next;
    logic            r_timeout;

    // Counting keys off the next outstanding value so the commit cycle that
    // creates the first outstanding result is itself counted. Saturates at
    // the limit so the counter never wraps back below it.
    always_comb begin
        w_wait_next = r_wait;
        if (w_result_hs) begin
            w_wait_next = '0;
        end else if ((w_outstanding_next != 4'd0) && (r_wait < TO_LIMIT)) begin
            w_wait_next = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wait <= w_wait_next;
            if (w_wait_next >= TO_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic [31:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = 32'(TimeoutCycles);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cvxif_offload_initiator.sv
// tb/tb_cvxif_offload_initiator.sv - self-checking bench for cvxif_offload_initiator
module tb_cvxif_offload_initiator;
    import cvxif_pkg::*;

    localparam int MAXO = 4;
    localparam int TOC  = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic [X_ID_WIDTH-1:0] id_in;
    logic                  flush;
    cvxif_req_t            req;
    cvxif_resp_t           resp;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [31:0]           wb_data;
    logic [X_ID_WIDTH-1:0] wb_id;
    logic                  illegal;
    logic                  busy;
    logic                  timeout;

    always #5 clk = ~clk;

    cvxif_offload_initiator #(.MaxOutstanding(MAXO), .TimeoutCycles(TOC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .instr_valid_i(instr_valid),
        .instr_ready_o(instr_ready),
        .instr_i      (instr),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .id_i         (id_in),
        .flush_i      (flush),
        .cvxif_req_o  (req),
        .cvxif_resp_i (resp),
        .wb_valid_o   (wb_valid),
        .wb_rd_o      (wb_rd),
        .wb_data_o    (wb_data),
        .wb_id_o      (wb_id),
        .illegal_o    (illegal),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: ids of accepted, committed instructions awaiting a result.
    logic [X_ID_WIDTH-1:0] pending[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        rs1         = '0;
        rs2         = '0;
        id_in       = '0;
        flush       = 1'b0;
        resp        = '0;
        pending.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one result; e returns the expected {we, rd, data, id} writeback.
    task automatic post_result(input logic [4:0] rd, input logic [31:0] data, input logic we,
                               output logic [41:0] e);
        logic [X_ID_WIDTH-1:0] rid;
        rid = (pending.size() > 0) ? pending[0] : X_ID_WIDTH'($urandom);
        resp.x_result_valid = 1'b1;
        resp.x_result.id    = rid;
        resp.x_result.rd    = rd;
        resp.x_result.data  = data;
        resp.x_result.we    = we;
        e = {we, rd, data, rid};
    endtask

    task automatic check_wb(input logic [41:0] e, input bit had_pending);
        check("writeback", {wb_valid, wb_rd, wb_data, wb_id}, e);
        resp.x_result_valid = 1'b0;
        if (had_pending) void'(pending.pop_front());
    endtask

    task automatic result_idle();
        logic [41:0] e;
        bit had;
        had = pending.size() > 0;
        post_result(5'($urandom), $urandom, 1'($urandom), e);
        @(negedge clk);
        check_wb(e, had);
        check("count_after_result", dut.r_outstanding, pending.size());
    endtask

    task automatic offload(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [X_ID_WIDTH-1:0] id, input int stall, input int delay,
                           input int flush_at, input logic acc, input logic wbk,
                           input bit res_at_commit);
        logic [41:0] e;
        bit flushed, kill, had;
        instr_valid = 1'b1;
        instr = ins; rs1 = a; rs2 = b; id_in = id;
        @(negedge clk);
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                check("stall_hold", {req.x_issue_valid, instr_ready, busy}, 3'b001);
                if (s == stall - 1) post_result(5'($urandom), $urandom, 1'($urandom), e);
                @(negedge clk);
            end
            check_wb(e, 1'b1);
        end
        check("issue_a", {req.x_issue_valid, req.x_issue_req.instr, req.x_issue_req.rs1},
              {1'b1, ins, a});
        check("issue_b", {req.x_issue_req.rs2, req.x_issue_req.rs_valid, req.x_issue_req.id},
              {b, 2'b11, id});
        for (int k = 0; k <= delay; k++) begin
            resp.x_issue_ready = (k == delay);
            resp.x_issue_resp.accept    = (k == delay) ? acc : 1'($urandom);
            resp.x_issue_resp.writeback = wbk;
            flush = (k == flush_at);
            @(negedge clk);
            if (k < delay)
                check("issue_stable", {req.x_issue_valid, req.x_commit_valid, req.x_issue_req.instr},
                      {2'b10, ins});
        end
        resp.x_issue_ready = 1'b0;
        flush = 1'b0;
        flushed = (flush_at >= 0) && (flush_at <= delay);
        kill = !acc || flushed;
        check("commit", {req.x_issue_valid, req.x_commit_valid, req.x_commit.id,
                         req.x_commit.commit_kill, instr_ready, illegal},
              {2'b01, id, kill, 1'b1, !acc && !flushed});
        had = pending.size() > 0;
        if (res_at_commit) post_result(5'($urandom), $urandom, 1'($urandom), e);
        if (!kill) pending.push_back(id);
        instr_valid = 1'b0;
        @(negedge clk);
        if (res_at_commit) check_wb(e, had);
        check("post_commit", {req.x_commit_valid, illegal, instr_ready}, 3'b000);
        check("count", dut.r_outstanding, pending.size());
    endtask

    initial begin
        logic [41:0] e;
        int stall, delay, flush_at;
        bit rac;

        // Reset state
        rst_n = 1'b0; instr_valid = 0; flush = 0; resp = '0; instr = '0;
        rs1 = '0; rs2 = '0; id_in = '0;
        @(negedge clk);
        check("reset_req", req, '0);
        check("reset_outs", {instr_ready, wb_valid, illegal, busy, timeout, wb_rd, wb_data, wb_id}, '0);
        do_reset();
        check("result_ready", req.x_result_ready, 1'b1);

        // Underflow: a result with nothing outstanding must not wrap the counter.
        result_idle();

        // Accept with the directed values, then the matching result.
        offload(32'h0000002B, 32'h01020304, 32'h01010101, 4'd3, 0, 0, -1, 1'b1, 1'b1, 1'b0);
        check("busy_outstanding", busy, 1'b1);
        post_result(5'd5, 32'h0000000A, 1'b1, e);
        @(negedge clk);
        check("accept_wb", {wb_valid, wb_rd, wb_data, wb_id}, {1'b1, 5'd5, 32'h0000000A, 4'd3});
        check_wb(e, 1'b1);
        check("busy_idle", busy, 1'b0);

        // Reject
        offload($urandom, $urandom, $urandom, 4'd7, 0, 1, -1, 1'b0, 1'b0, 1'b0);
        check("reject_busy", busy, 1'b0);

        // Flush during ISSUE with ready held low three cycles
        offload($urandom, $urandom, $urandom, 4'd9, 0, 3, 1, 1'b1, 1'b1, 1'b0);
        check("flush_busy", busy, 1'b0);

        // Flush while idle has no effect on the next candidate
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        offload($urandom, $urandom, $urandom, 4'd1, 0, 0, -1, 1'b1, 1'b0, 1'b0);
        // Simultaneous commit and result: counter unchanged
        offload($urandom, $urandom, $urandom, 4'd2, 0, 0, -1, 1'b1, 1'b0, 1'b1);
        while (pending.size() > 0) result_idle();

        // Credits: fill to MaxOutstanding, fifth candidate stalls until a result
        for (int i = 0; i < MAXO; i++)
            offload($urandom, $urandom, $urandom, 4'(i), 0, 0, -1, 1'b1, 1'b1, 1'b0);
        offload($urandom, $urandom, $urandom, 4'd4, 3, 0, -1, 1'b1, 1'b1, 1'b0);
        while (pending.size() > 0) result_idle();

        // Reset in the middle of a transaction
        instr_valid = 1'b1; instr = 32'h1234_5678; id_in = 4'd6;
        @(negedge clk);
        check("pre_reset_issue", req.x_issue_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset", {req.x_issue_valid, req.x_commit_valid, busy}, 3'b000);
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b1;
        pending.delete();
        repeat (2) begin
            @(negedge clk);
            check("no_commit_after_reset", {req.x_commit_valid, busy}, 2'b00);
        end

        // Randomized traffic against the queue model
        for (int t = 0; t < 40; t++) begin
            if (pending.size() > 0 && pending.size() < MAXO && ($urandom % 3) == 0) result_idle();
            stall    = (pending.size() == MAXO) ? 1 + int'($urandom % 3) : 0;
            delay    = int'($urandom % 4);
            flush_at = (($urandom % 5) == 0) ? int'($urandom % (delay + 1)) : -1;
            rac      = (stall == 0) && (pending.size() > 0) && (($urandom % 4) == 0);
            offload($urandom, $urandom, $urandom, 4'($urandom), stall, delay, flush_at,
                    1'(($urandom % 4) != 0), 1'($urandom), rac);
            check("rand_busy", busy, pending.size() != 0);
        end
        while (pending.size() > 0) result_idle();
        check("drain_busy", busy, 1'b0);

        // Result-wait timeout
        do_reset();
        check("timeout_reset", timeout, 1'b0);
        offload($urandom, $urandom, $urandom, 4'd5, 0, 0, -1, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
`ifdef CVXIF_INITIATOR_TIMEOUT_EN
            if (k == 15) check("timeout_early", timeout, 1'b0);
            if (k == 16) check("timeout_set", timeout, 1'b1);
`endif
        end
`ifdef CVXIF_INITIATOR_TIMEOUT_EN
        result_idle();
        check("timeout_sticky", timeout, 1'b1);
`else
        check("timeout_tied", timeout, 1'b0);
        result_idle();
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("timeout_cleared", timeout, 1'b0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
